// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, host and RAM side signals of the data memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;

  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // master: the arbiter itself
  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output cpu_rdata, cpu_hold,
    input  host_valid, host_we, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  cpu_rdata, cpu_hold,
    output host_valid, host_we, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - fixed-priority CPU/host arbiter for the single-port data RAM
// The host is guaranteed service by a one-cycle CPU hold after STARVE_LIMIT blocked cycles.
module dmem_arbiter #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.master bus
);

  typedef enum logic {
    NORMAL = 1'b0,
    HOLD   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_wdata_q;
  logic              rd_p1_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] hrdata_q;
  logic              cpu_gnt;
  logic              host_gnt;
  logic              blocked;

  assign cpu_gnt  = (state_q == NORMAL) && (bus.cpu_re || bus.cpu_we);
  assign host_gnt = !cpu_gnt && bus.host_valid;
  assign blocked  = bus.host_valid && !host_gnt;

  // With no owner the address/data bus keeps its last value to avoid needless toggling
  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr  : (host_gnt ? bus.host_addr  : last_addr_q);
  assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : (host_gnt ? bus.host_wdata : last_wdata_q);
  assign bus.mem_we    = !rst && (cpu_gnt ? bus.cpu_we : (host_gnt && bus.host_we));
  assign bus.host_ready = !rst && host_gnt;

  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.cpu_hold    = (state_q == HOLD);
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_rdata  = hrdata_q;

  always_comb begin
    state_d = NORMAL;
    cnt_d   = '0;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    if (blocked) begin
      if ((state_q == NORMAL) && (STARVE_LIMIT != 0) && (cnt_inc == CNT_W'(STARVE_LIMIT))) begin
        state_d = HOLD;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= NORMAL;
      cnt_q        <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
      rd_p1_q      <= 1'b0;
      rvalid_q     <= 1'b0;
      hrdata_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cpu_gnt) begin
        last_addr_q  <= bus.cpu_addr;
        last_wdata_q <= bus.cpu_wdata;
      end else if (host_gnt) begin
        last_addr_q  <= bus.host_addr;
        last_wdata_q <= bus.host_wdata;
      end
      // Host read: address in cycle N, RAM data in N+1, registered response in N+2
      rd_p1_q  <= host_gnt && !bus.host_we;
      rvalid_q <= rd_p1_q;
      if (rd_p1_q) begin
        hrdata_q <= bus.mem_rdata;
      end
    end
  end

endmodule
